// File: rtl/bcd_display_mux.sv
// bcd_display_mux: scans four snapshotted BCD digits onto a multiplexed 7-segment display
// with leading-zero blanking and an anode-off guard at the start of each digit slot.
module bcd_display_mux #(
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 4,
    parameter bit SEG_ACTIVE_LOW = 1,
    parameter bit AN_ACTIVE_LOW  = 1,
    parameter bit BLANK_LEADING  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] G = CW'(GUARD);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF = AN_ACTIVE_LOW ? 4'hF : 4'h0;
    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic [3:0][3:0] snap;
    logic [3:0]      blk;
    logic [6:0]      dec;
    logic            wrap_slot, wrap_scan, guard;
    assign wrap_slot = cnt == LAST;
    assign wrap_scan = wrap_slot && idx == 2'd3;
    assign guard = cnt < G;
    // blanking ripples down from the thousands digit; units always shown
    assign blk[3] = BLANK_LEADING && snap[3] == 4'd0;
    assign blk[2] = blk[3] && snap[2] == 4'd0;
    assign blk[1] = blk[2] && snap[1] == 4'd0;
    assign blk[0] = 1'b0;
    always_comb begin
        dec = 7'h40;
        case (snap[idx])
            4'd0: dec = 7'h3F;
            4'd1: dec = 7'h06;
            4'd2: dec = 7'h5B;
            4'd3: dec = 7'h4F;
            4'd4: dec = 7'h66;
            4'd5: dec = 7'h6D;
            4'd6: dec = 7'h7D;
            4'd7: dec = 7'h07;
            4'd8: dec = 7'h7F;
            4'd9: dec = 7'h6F;
            default: dec = 7'h40;
        endcase
        if (blk[idx]) dec = 7'h00;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            idx   <= '0;
            snap  <= '0;
            frame <= 1'b0;
            seg   <= SEG_OFF;
            an    <= AN_OFF;
        end else begin
            cnt   <= wrap_slot ? '0 : cnt + 1'b1;
            idx   <= wrap_slot ? idx + 2'd1 : idx;
            frame <= wrap_scan;
            if (wrap_scan) snap <= {digit3, digit2, digit1, digit0};
            an    <= guard ? AN_OFF : (4'b0001 << idx) ^ AN_OFF;
            seg   <= guard ? SEG_OFF : dec ^ SEG_OFF;
        end
    end
endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
Downstream consumer of the four-digit BCD counter. Takes four BCD digits (units..thousands) and drives a common-anode/cathode 4-digit multiplexed 7-segment display. Scans one digit at a time at a programmable refresh rate, snapshots the inputs once per full scan to prevent tearing, and blanks leading zeros. Inserts a short anode-off guard interval at each digit change to suppress ghosting.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot; legal range ≥ 2.
GUARD, 4, cycles at the start of each slot with all anodes inactive; legal range 0 ≤ GUARD < REFRESH_DIV.
SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (lit = 0).
AN_ACTIVE_LOW, 1, 1 = anode outputs inverted (selected = 0).
BLANK_LEADING, 1, 1 = enable leading-zero blanking.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
digit0  input  4  BCD units
digit1  input  4  BCD tens
digit2  input  4  BCD hundreds
digit3  input  4  BCD thousands
seg  output  7  segments {g,f,e,d,c,b,a}, seg[0]=a
an  output  4  digit enables, an[k] selects digit k
frame  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (reset=0, async):
  - refresh counter cnt=0, slot index idx=0, snapshot registers snap0..3=0, frame=0.
  - an = all inactive (4'hF if AN_ACTIVE_LOW, else 4'h0).
  - seg = all off (7'h7F if SEG_ACTIVE_LOW, else 7'h00).
- Refresh counter: cnt width = clog2(REFRESH_DIV). cnt increments every clk.
  - At cnt == REFRESH_DIV-1: cnt→0 and idx→idx+1 (2-bit, 3→0 wraps).
- Snapshot:
  - On the same edge where idx goes 3→0, snap0..3 ← digit0..3 and frame ← 1 for exactly one cycle. frame is 0 otherwise.
  - Until the first wrap after reset, snap = 0.
- Blanking (when BLANK_LEADING=1), evaluated on the snapshot:
  - blank3 = (snap3==0)
  - blank2 = blank3 & (snap2==0)
  - blank1 = blank2 & (snap1==0)
  - digit 0 is never blanked.
  - When BLANK_LEADING=0, nothing is blanked.
- Decode, active-high, before polarity is applied:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Invalid BCD 10–15 → 40 (dash, segment g only).
  - Blanked digit → 00.
- Outputs are registered, with 1-cycle latency from state. On each edge, seg/an are computed from the pre-edge (cnt, idx, snap):
  - If cnt < GUARD: an = all inactive, seg = all off.
  - Else: an = one-hot(idx) and seg = decode(snap[idx]).
  - Polarity inversion is applied last.
- Slot timing: each digit's anode is active for REFRESH_DIV−GUARD cycles per slot. Full scan period = 4·REFRESH_DIV cycles.
- Inputs may change on any cycle. Only values present at the snapshot edge are displayed. No combinational path from digitN to outputs.
- Reset asserted mid-scan: immediate return to reset values. Scanning restarts at idx=0, cnt=0 on the first clk after release.

Test Plan:
1. Reset check. Sim params: REFRESH_DIV=4, GUARD=1, both active-low, blanking on. Hold reset=0 → an=F, seg=7F, frame=0. Release → idx cycles 0,1,2,3 every 4 clks; frame pulses once per 16 clks on the idx 3→0 edge.
2. Decode and guard. digits=1,2,3,4 (thousands=4), after first frame → per slot: 1 guard cycle with an=F, seg=7F; then 3 cycles of:
   - slot0: an=E, seg=~06=79
   - slot1: an=D, seg=~5B=24
   - slot2: an=B, seg=~4F=30
   - slot3: an=7, seg=~66=19
3. Leading-zero blanking. digits (3..0)=0,0,0,7 → digits 3,2,1 show seg=7F with their anodes active; digit0 seg=~07=78. Then digits=0,0,0,0 → digit0 shows ~3F=40, others blank. Then 0,1,0,0 → digit3 blank, digit2 shows ~06=79, digit1 and digit0 show ~3F=40.
4. Invalid BCD. digit1=4'hC, others 0 → slot1 seg=~40=3F (dash). Blanking of digit3/digit2 is unaffected.
5. Snapshot coherence. Change digit0 from 5 to 9 mid-scan at idx=1 → display holds 5 (seg=~6D=12) through the rest of the scan. Shows 9 (seg=~6F=10) only after the next frame pulse.
6. Async reset mid-operation. Assert reset at idx=2, cnt=2, asynchronous to clk → an=F, seg=7F immediately, snap cleared (display shows single "0" after release). frame stays 0 until 16 clks after release.
